// File: rtl/pipo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pipo_rr_arbiter
//  Description : Four-way round-robin arbiter feeding a single-entry output
//                pipeline register with ready/valid handshake and a wrapping
//                8-bit completed-transfer counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipo_rr_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] d3,
    output logic [3:0]    gnt,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic [1:0]    q_src,
    input  logic          q_ready,
    output logic [7:0]    xfer_cnt
);

    logic [DW-1:0] r_q;
    logic          r_q_valid;
    logic [1:0]    r_q_src;
    logic [1:0]    r_rr_ptr;
    logic [7:0]    r_xfer_cnt;

    logic          w_load_slot;
    logic          w_drain;
    logic [3:0]    w_req_rot;
    logic [1:0]    w_off;
    logic          w_any;
    logic [1:0]    w_gnt_idx;
    logic          w_grant_en;
    logic [3:0]    w_gnt;
    logic [DW-1:0] w_gnt_data;

    // The register can accept a new word when empty or when it drains this edge.
    assign w_load_slot = !r_q_valid || q_ready;
    assign w_drain     = r_q_valid && q_ready;

    // Rotate requests so bit 0 is the requester currently holding priority.
    always_comb begin
        w_req_rot = req;
        case (r_rr_ptr)
            2'd0:    w_req_rot = req;
            2'd1:    w_req_rot = {req[0],   req[3:1]};
            2'd2:    w_req_rot = {req[1:0], req[3:2]};
            default: w_req_rot = {req[2:0], req[3]};
        endcase
    end

    // Lowest set bit of the rotated vector is the winner's distance from rr_ptr.
    always_comb begin
        w_off = 2'd0;
        w_any = |w_req_rot;
        if (w_req_rot[0])      w_off = 2'd0;
        else if (w_req_rot[1]) w_off = 2'd1;
        else if (w_req_rot[2]) w_off = 2'd2;
        else                   w_off = 2'd3;
    end

    // Two-bit addition wraps naturally from requester 3 back to 0.
    assign w_gnt_idx  = r_rr_ptr + w_off;
    // Reset gating keeps the strobe quiet while reset_n is held low.
    assign w_grant_en = reset_n && w_load_slot && w_any;
    assign w_gnt      = w_grant_en ? (4'b0001 << w_gnt_idx) : 4'b0000;

    // Only the granted requester's data is selected, so unrequested inputs never reach q.
    always_comb begin
        w_gnt_data = d0;
        case (w_gnt_idx)
            2'd0:    w_gnt_data = d0;
            2'd1:    w_gnt_data = d1;
            2'd2:    w_gnt_data = d2;
            default: w_gnt_data = d3;
        endcase
    end

    // Output register: load on grant, empty when a slot opens with no request, hold on stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_q_src   <= 2'd0;
            r_rr_ptr  <= 2'd0;
        end else if (w_load_slot) begin
            if (w_any) begin
                r_q       <= w_gnt_data;
                r_q_src   <= w_gnt_idx;
                r_q_valid <= 1'b1;
                r_rr_ptr  <= w_gnt_idx + 2'd1;
            end else begin
                r_q_valid <= 1'b0;
            end
        end
    end

    // Completed-handshake counter, wraps at 256.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_xfer_cnt <= 8'd0;
        end else if (w_drain) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end

    assign gnt      = w_gnt;
    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign q_src    = r_q_src;
    assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipo_rr_arbiter
//  Description : Self-checking bench for pipo_rr_arbiter: directed vector
//                table, hand-written corner sequences and a randomized run
//                against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipo_rr_arbiter;

    localparam int DW = 4;

    logic          clk;
    logic          reset_n;
    logic [3:0]    req;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [3:0]    gnt;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [1:0]    q_src;
    logic          q_ready;
    logic [7:0]    xfer_cnt;

    int n_vec;
    int n_err;

    pipo_rr_arbiter #(.DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .q_src    (q_src),
        .q_ready  (q_ready),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_q;
    logic          m_valid;
    int            m_src;
    int            m_ptr;
    int            m_cnt;

    // Winner index from the round-robin rule, or -1 if nobody is granted.
    function automatic int model_grant(input logic [3:0] r, input int ptr, input logic valid, input logic rdy);
        int order[4];
        if (valid && !rdy) return -1;
        for (int k = 0; k < 4; k++) order[k] = (ptr + k) % 4;
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    function automatic logic [DW-1:0] pick(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b0000;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_q = '0; m_valid = 1'b0; m_src = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Applies the model's clock-edge update using the currently driven inputs.
    task automatic model_edge();
        int g;
        g = model_grant(req, m_ptr, m_valid, q_ready);
        if (m_valid && q_ready) m_cnt = (m_cnt + 1) % 256;
        if (!m_valid || q_ready) begin
            if (g >= 0) begin
                m_q = pick(g); m_src = g; m_valid = 1'b1; m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " q_valid"},  32'(q_valid),  32'(m_valid));
        chk({tag, " q"},        32'(q),        32'(m_q));
        chk({tag, " q_src"},    32'(q_src),    32'(m_src));
        chk({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]    req;
        logic          rdy;
        logic [3:0]    gnt;
        logic [DW-1:0] q;
        logic          valid;
        logic [1:0]    src;
        logic [7:0]    cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        req = 4'b1111;
        q_ready = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        model_reset();

        // Reset state with requests pending: no grant, all outputs cleared.
        #3;
        chk("reset gnt",      32'(gnt),      32'h0);
        chk("reset q",        32'(q),        32'h0);
        chk("reset q_valid",  32'(q_valid),  32'h0);
        chk("reset q_src",    32'(q_src),    32'h0);
        chk("reset xfer_cnt", 32'(xfer_cnt), 32'h0);
        @(posedge clk);
        #1;
        chk("reset held q_valid", 32'(q_valid), 32'h0);
        reset_n = 1'b1;

        //            req      rdy   gnt      q     v     src   cnt
        tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 4'h1, 1'b1, 2'd0, 8'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 4'h2, 1'b1, 2'd1, 8'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 4'h3, 1'b1, 2'd2, 8'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 4'h4, 1'b1, 2'd3, 8'd3};
        tbl[4]  = '{4'b1001, 1'b1, 4'b0001, 4'h1, 1'b1, 2'd0, 8'd4};
        tbl[5]  = '{4'b1001, 1'b1, 4'b1000, 4'h4, 1'b1, 2'd3, 8'd5};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 4'h4, 1'b0, 2'd3, 8'd6};
        tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 4'h3, 1'b1, 2'd2, 8'd6};
        tbl[8]  = '{4'b0010, 1'b0, 4'b0000, 4'h3, 1'b1, 2'd2, 8'd6};
        tbl[9]  = '{4'b0010, 1'b1, 4'b0010, 4'h2, 1'b1, 2'd1, 8'd7};
        tbl[10] = '{4'b0011, 1'b1, 4'b0001, 4'h1, 1'b1, 2'd0, 8'd8};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 4'h1, 1'b1, 2'd0, 8'd8};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 4'h1, 1'b0, 2'd0, 8'd9};

        foreach (tbl[i]) begin
            req = tbl[i].req;
            q_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl[%0d] gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            step();
            chk($sformatf("tbl[%0d] q", i),        32'(q),        32'(tbl[i].q));
            chk($sformatf("tbl[%0d] q_valid", i),  32'(q_valid),  32'(tbl[i].valid));
            chk($sformatf("tbl[%0d] q_src", i),    32'(q_src),    32'(tbl[i].src));
            chk($sformatf("tbl[%0d] xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].cnt));
        end

        // Single request straight after reset, one-cycle latency, count follows.
        req = 4'b0000;
        do_reset();
        req = 4'b0001; d0 = 4'hA; q_ready = 1'b1;
        #1;
        chk("first gnt", 32'(gnt), 32'b0001);
        step();
        chk("first q",       32'(q),       32'hA);
        chk("first q_src",   32'(q_src),   32'h0);
        chk("first q_valid", 32'(q_valid), 32'h1);
        req = 4'b0000;
        step();
        chk("first xfer_cnt", 32'(xfer_cnt), 32'd1);

        // Stall holds q=5 for three cycles, then drain and reload in the same edge.
        req = 4'b0001; d0 = 4'h5; d2 = 4'h7; q_ready = 1'b1;
        step();
        req = 4'b0100; q_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d gnt", c), 32'(gnt), 32'h0);
            step();
            chk($sformatf("stall%0d q", c), 32'(q), 32'h5);
            chk($sformatf("stall%0d q_valid", c), 32'(q_valid), 32'h1);
        end
        q_ready = 1'b1;
        #1;
        chk("unstall gnt", 32'(gnt), 32'b0100);
        step();
        chk("unstall q",     32'(q),     32'h7);
        chk("unstall q_src", 32'(q_src), 32'h2);

        // Full-throughput stream with counter wrap, then an asynchronous reset pulse.
        req = 4'b0000;
        do_reset();
        req = 4'b1111; q_ready = 1'b1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        step();
        for (int c = 0; c < 256; c++) begin
            if (c < 8) begin
                chk($sformatf("stream%0d q", c), 32'(q), 32'((c % 4) + 1));
                chk($sformatf("stream%0d q_src", c), 32'(q_src), 32'(c % 4));
                chk($sformatf("stream%0d q_valid", c), 32'(q_valid), 32'h1);
            end
            step();
        end
        chk("wrap xfer_cnt", 32'(xfer_cnt), 32'h0);
        step();
        chk("post-wrap xfer_cnt", 32'(xfer_cnt), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async q",        32'(q),        32'h0);
        chk("async q_valid",  32'(q_valid),  32'h0);
        chk("async q_src",    32'(q_src),    32'h0);
        chk("async xfer_cnt", 32'(xfer_cnt), 32'h0);
        chk("async gnt",      32'(gnt),      32'h0);
        #2;
        reset_n = 1'b1;
        #1;
        chk("release gnt", 32'(gnt), 32'b0001);
        step();
        chk("release q",     32'(q),     32'h1);
        chk("release q_src", 32'(q_src), 32'h0);

        // Randomized traffic against the reference model.
        req = 4'b0000;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req     = 4'($urandom);
            q_ready = ($urandom_range(0, 3) != 0);
            d0 = DW'($urandom); d1 = DW'($urandom);
            d2 = DW'($urandom); d3 = DW'($urandom);
            #1;
            chk($sformatf("rand%0d gnt", c), 32'(gnt),
                32'(onehot(model_grant(req, m_ptr, m_valid, q_ready))));
            model_edge();
            step();
            check_model($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
